async_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_mem.sv | 33 +++
 rtl/async_fifo.sv | 60 ++++++
 tb/tb_async_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizes and pointer type for the
// single-clock fall-through FIFO.
package fifo_pkg;

  localparam int DATA_SIZE = 8;
  localparam int ADDR_SIZE = 5;
  localparam int DEPTH     = 2 ** ADDR_SIZE;

  typedef logic [ADDR_SIZE:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register-file storage, sync write,
// async read, async clear.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int data_Size    = DATA_SIZE,
  parameter int address_Size = ADDR_SIZE
) (
  input  logic                    w_Clk,
  input  logic                    w_Rst,
  input  logic                    w_En,
  input  logic [address_Size-1:0] w_Addr,
  input  logic [data_Size-1:0]    w_Data,
  input  logic [address_Size-1:0] r_Addr,
  output logic [data_Size-1:0]    r_Data
);

  localparam int Depth = 2 ** address_Size;

  logic [data_Size-1:0] mem [Depth];

  always_ff @(posedge w_Clk or negedge w_Rst) begin
    if (!w_Rst) begin
      for (int i = 0; i < Depth; i++)
        mem[i] <= '0;
    end else if (w_En) begin
      mem[w_Addr] <= w_Data;
    end
  end

  assign r_Data = mem[r_Addr];

endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock fall-through FIFO; wrap-bit
// pointers distinguish full from empty.
module async_fifo
  import fifo_pkg::*;
#(
  parameter int data_Size    = DATA_SIZE,
  parameter int address_Size = ADDR_SIZE
) (
  input  logic                 w_Clk,
  input  logic                 w_Rst,
  input  logic                 w_Inc,
  input  logic [data_Size-1:0] write_Data,
  input  logic                 r_Inc,
  output logic [data_Size-1:0] read_Data,
  output logic                 fifo_Full,
  output logic                 fifo_Empty
);

  localparam int A = address_Size;

  logic [A:0] wr_ptr;
  logic [A:0] rd_ptr;
  logic       wr_en;
  logic       rd_en;

  assign fifo_Empty = (wr_ptr == rd_ptr);
  assign fifo_Full  = (wr_ptr[A] != rd_ptr[A]) &&
                      (wr_ptr[A-1:0] == rd_ptr[A-1:0]);

  // Gated by pre-edge flags, so full+both pops only,
  // empty+both pushes only.
  assign wr_en = w_Inc && !fifo_Full;
  assign rd_en = r_Inc && !fifo_Empty;

  always_ff @(posedge w_Clk or negedge w_Rst) begin
    if (!w_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + {{A{1'b0}}, 1'b1};
      if (rd_en)
        rd_ptr <= rd_ptr + {{A{1'b0}}, 1'b1};
    end
  end

  fifo_mem #(
    .data_Size   (data_Size),
    .address_Size(address_Size)
  ) u_mem (
    .w_Clk (w_Clk),
    .w_Rst (w_Rst),
    .w_En  (wr_en),
    .w_Addr(wr_ptr[A-1:0]),
    .w_Data(write_Data),
    .r_Addr(rd_ptr[A-1:0]),
    .r_Data(read_Data)
  );

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed checks of flags, ordering,
// full boundary, simultaneous ops and async reset.
`timescale 1ns/1ps
module tb_async_fifo;

  logic       w_Clk = 1'b0;
  logic       w_Rst;
  logic       w_Inc;
  logic [7:0] write_Data;
  logic       r_Inc;
  logic [7:0] read_Data;
  logic       fifo_Full;
  logic       fifo_Empty;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q [$];
  logic [7:0] exp_hd;

  always #5 w_Clk = ~w_Clk;

  async_fifo dut (
    .w_Clk     (w_Clk),
    .w_Rst     (w_Rst),
    .w_Inc     (w_Inc),
    .write_Data(write_Data),
    .r_Inc     (r_Inc),
    .read_Data (read_Data),
    .fifo_Full (fifo_Full),
    .fifo_Empty(fifo_Empty)
  );

  task automatic tick();
    @(posedge w_Clk);
    #1;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs,
                      logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(logic [7:0] d);
    w_Inc      = 1'b1;
    write_Data = d;
    tick();
    w_Inc      = 1'b0;
  endtask

  task automatic rd();
    r_Inc = 1'b1;
    tick();
    r_Inc = 1'b0;
  endtask

  initial begin
    logic [7:0] ten [10];
    ten = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d,
            8'h8d, 8'h65, 8'h12, 8'h01, 8'h0d};

    w_Rst      = 1'b0;
    w_Inc      = 1'b0;
    r_Inc      = 1'b0;
    write_Data = 8'h00;
    tick();
    chk1("rst_empty", fifo_Empty, 1'b1);
    chk1("rst_full", fifo_Full, 1'b0);
    chk8("rst_data", read_Data, 8'h00);
    w_Rst = 1'b1;

    rd();
    chk1("idle_rd_empty", fifo_Empty, 1'b1);
    chk1("idle_rd_full", fifo_Full, 1'b0);
    chk8("idle_rd_data", read_Data, 8'h00);

    wr(8'h24);
    chk1("single_empty", fifo_Empty, 1'b0);
    chk8("single_data", read_Data, 8'h24);
    rd();
    chk1("single_pop_empty", fifo_Empty, 1'b1);

    for (int i = 0; i < 10; i++)
      wr(ten[i]);
    for (int i = 0; i < 10; i++) begin
      chk1("ten_not_empty", fifo_Empty, 1'b0);
      chk8("ten_data", read_Data, ten[i]);
      rd();
      tick();
    end
    chk1("ten_drained", fifo_Empty, 1'b1);

    for (int i = 0; i < 33; i++) begin
      wr(8'(i));
      if (i == 30)
        chk1("full_at_31", fifo_Full, 1'b0);
      if (i == 31)
        chk1("full_at_32", fifo_Full, 1'b1);
    end
    chk1("full_after_33", fifo_Full, 1'b1);
    for (int i = 0; i < 32; i++) begin
      chk8("full_rd_data", read_Data, 8'(i));
      rd();
      if (i == 0)
        chk1("full_falls", fifo_Full, 1'b0);
    end
    chk1("full_drained", fifo_Empty, 1'b1);

    for (int i = 0; i < 5; i++) begin
      wr(8'(8'h60 + i));
      q.push_back(8'(8'h60 + i));
    end
    w_Inc = 1'b1;
    r_Inc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      write_Data = 8'(8'h80 + i);
      exp_hd = q[0];
      chk8("sim_data", read_Data, exp_hd);
      tick();
      void'(q.pop_front());
      q.push_back(8'(8'h80 + i));
      chk1("sim_empty", fifo_Empty, 1'b0);
      chk1("sim_full", fifo_Full, 1'b0);
    end
    w_Inc = 1'b0;
    r_Inc = 1'b0;
    chk8("sim_occ", 8'(q.size()), 8'd5);
    for (int i = 0; i < 27; i++) begin
      wr(8'(8'hc0 + i));
      q.push_back(8'(8'hc0 + i));
    end
    chk1("sim_filled", fifo_Full, 1'b1);
    w_Inc      = 1'b1;
    r_Inc      = 1'b1;
    write_Data = 8'hee;
    tick();
    w_Inc = 1'b0;
    r_Inc = 1'b0;
    void'(q.pop_front());
    chk1("full_both_full", fifo_Full, 1'b0);
    chk8("full_both_head", read_Data, q[0]);
    for (int i = 0; i < 31; i++) begin
      chk8("full_both_drain", read_Data, q[0]);
      void'(q.pop_front());
      rd();
    end
    chk1("full_both_empty", fifo_Empty, 1'b1);

    for (int i = 0; i < 7; i++)
      wr(8'(8'h30 + i));
    chk1("pre_rst_empty", fifo_Empty, 1'b0);
    chk8("pre_rst_data", read_Data, 8'h30);
    #2;
    w_Rst = 1'b0;
    #1;
    chk1("async_rst_empty", fifo_Empty, 1'b1);
    chk1("async_rst_full", fifo_Full, 1'b0);
    chk8("async_rst_data", read_Data, 8'h00);
    tick();
    w_Rst = 1'b1;
    wr(8'h5a);
    chk1("post_rst_empty", fifo_Empty, 1'b0);
    chk8("post_rst_data", read_Data, 8'h5a);
    rd();
    chk1("post_rst_drained", fifo_Empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
